round_pipe: RTL and testbench

Parametrised, elastic pipeline register chain for the cipher datapath, replacing fixed single-stage round flops between rounds. Carries a WIDTH-bit round word through DEPTH register stages with a valid/ready handshake, so downstream stalls propagate upstream without dropping or duplicating words. Each stage is a two-entry skid slice: full throughput (one word per cycle) and a registered ready path. Sits between round-function blocks and between the last round and the output formatter.

---
 rtl/round_pipe.sv | 107 ++++++++++
 tb/tb_round_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/round_pipe.sv
// Elastic round-word pipeline: DEPTH two-entry skid slices with valid/ready flow control.
// Optional synchronous flush port is enabled by defining ROUND_PIPE_FLUSH_EN.
module round_pipe #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   localparam int CW = $clog2(2*DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
`ifdef ROUND_PIPE_FLUSH_EN
   input  logic             flush,
`endif
   output logic [CW-1:0]    occupancy
);

   logic [DEPTH-1:0] main_v;
   logic [DEPTH-1:0] skid_v;
   logic [DEPTH-1:0] up_valid;
   logic [DEPTH-1:0] dn_ready;
   logic [WIDTH-1:0] main_d  [DEPTH];
   logic [WIDTH-1:0] skid_d  [DEPTH];
   logic [WIDTH-1:0] up_data [DEPTH];
   logic             flush_now;

`ifdef ROUND_PIPE_FLUSH_EN
   assign flush_now = flush;
`else
   assign flush_now = 1'b0;
`endif

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             mv;
      logic             sv;
      logic [WIDTH-1:0] md;
      logic [WIDTH-1:0] sd;
      logic             acc;
      logic             drn;

      if (k == 0) begin : g_head
         assign up_valid[k] = in_valid;
         assign up_data[k]  = in_data;
      end else begin : g_link
         assign up_valid[k] = main_v[k-1];
         assign up_data[k]  = main_d[k-1];
      end

      // Downstream ready of a stage is the registered !skid_v of the next one.
      if (k == DEPTH-1) begin : g_tail
         assign dn_ready[k] = out_ready;
      end else begin : g_mid
         assign dn_ready[k] = !skid_v[k+1];
      end

      assign acc = up_valid[k] & ~sv;
      assign drn = mv & dn_ready[k];

      always_ff @(posedge clk) begin
         if (rst) begin
            mv <= 1'b0;
            sv <= 1'b0;
            md <= '0;
            sd <= '0;
         end else if (flush_now) begin
            mv <= 1'b0;
            sv <= 1'b0;
         end else if (sv) begin
            if (drn) begin
               md <= sd;
               sv <= 1'b0;
            end
         end else if (acc) begin
            if (!mv || drn) begin
               md <= up_data[k];
               mv <= 1'b1;
            end else begin
               sd <= up_data[k];
               sv <= 1'b1;
            end
         end else if (drn) begin
            mv <= 1'b0;
         end
      end

      assign main_v[k] = mv;
      assign skid_v[k] = sv;
      assign main_d[k] = md;
      assign skid_d[k] = sd;
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + CW'(main_v[i]) + CW'(skid_v[i]);
      end
   end

   assign in_ready  = !skid_v[0];
   assign out_valid = main_v[DEPTH-1];
   assign out_data  = main_d[DEPTH-1];

endmodule

// File: tb/tb_round_pipe.sv
// Self-checking bench for round_pipe: FIFO queue model checked every cycle plus directed literal checks.
module tb_round_pipe;
   localparam int WIDTH = 64;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(2*DEPTH+1);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic             flush;
   logic [CW-1:0]    occupancy;

   int checks = 0;
   int passes = 0;
   bit mon_en = 1'b0;
   logic [WIDTH-1:0] model_q   [$];
   logic [WIDTH-1:0] delivered [$];

   always #5 clk = ~clk;

   round_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
`ifdef ROUND_PIPE_FLUSH_EN
      .flush     (flush),
`endif
      .occupancy (occupancy)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
   endtask

   task automatic drain();
      applyStimulus(1'b0, '0, 1'b1);
      for (int i = 0; i < 50 && occupancy != 0; i++) tick();
      checkOutput("drain_empty", 64'(occupancy), 64'd0);
   endtask

   // Reference model: the pipe is an ordered queue of accepted, not yet delivered words.
   always @(negedge clk) begin
      if (mon_en) begin
         checkOutput("occupancy_vs_model", 64'(occupancy), 64'(model_q.size()));
         checkOutput("occupancy_bound", 64'(occupancy <= CW'(2*DEPTH)), 64'd1);
         if (out_valid === 1'b1) begin
            checkOutput("out_valid_nonempty", 64'(model_q.size() > 0), 64'd1);
            if (model_q.size() > 0) checkOutput("out_data_order", out_data, model_q[0]);
         end
         if (rst) begin
            model_q.delete();
         end else if (flush) begin
            if (out_valid && out_ready) delivered.push_back(out_data);
            model_q.delete();
         end else begin
            if (out_valid && out_ready) begin
               delivered.push_back(out_data);
               if (model_q.size() > 0) void'(model_q.pop_front());
            end
            if (in_valid && in_ready) model_q.push_back(in_data);
         end
      end
   end

   initial begin
      int acc;
      int rise;
      int exp_occ;

      rst = 1'b1;
      flush = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      tick();
      tick();
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_out_data", out_data, 64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset_occupancy", 64'(occupancy), 64'd0);
      rst = 1'b0;
      mon_en = 1'b1;

      // Streaming 0..9 with no stall: latency two edges, no bubbles.
      delivered.delete();
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(k <= 10, WIDTH'(k-1), 1'b1);
         tick();
         if (k >= 2 && k <= 11) begin
            checkOutput("stream_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stream_out_data", out_data, 64'(k-2));
         end else begin
            checkOutput("stream_out_idle", 64'(out_valid), 64'd0);
         end
         exp_occ = (k == 1 || k == 11) ? 1 : (k == 12) ? 0 : 2;
         checkOutput("stream_occupancy", 64'(occupancy), 64'(exp_occ));
      end
      drain();
      checkOutput("stream_count", 64'(delivered.size()), 64'd10);
      for (int i = 0; i < 10 && i < delivered.size(); i++)
         checkOutput("stream_word", delivered[i], 64'(i));

      // Stall from empty: exactly 2*DEPTH words taken, then release.
      delivered.delete();
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 64'h100 + 64'(i), 1'b0);
         if (in_ready) acc++;
         tick();
      end
      checkOutput("stall_accepts", 64'(acc), 64'd4);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_occupancy", 64'(occupancy), 64'd4);
      checkOutput("stall_head", out_data, 64'h100);
      rise = 0;
      acc = 0;
      for (int j = 1; j <= 8; j++) begin
         applyStimulus(1'b1, 64'h200 + 64'(j), 1'b1);
         if (in_ready) acc++;
         tick();
         if (in_ready && rise == 0) rise = j;
      end
      checkOutput("release_in_ready_delay", 64'(rise >= 1 && rise <= DEPTH), 64'd1);
      drain();
      checkOutput("release_count", 64'(delivered.size()), 64'(4 + acc));
      for (int i = 0; i < 4 && i < delivered.size(); i++)
         checkOutput("release_word", delivered[i], 64'h100 + 64'(i));

      // Reset with three words in flight, then a short stream.
      delivered.delete();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 64'h300 + 64'(i), 1'b0);
         tick();
      end
      checkOutput("prereset_occupancy", 64'(occupancy), 64'd3);
      rst = 1'b1;
      applyStimulus(1'b1, 64'h3FF, 1'b0);
      tick();
      rst = 1'b0;
      checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midreset_out_data", out_data, 64'd0);
      checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
      checkOutput("midreset_occupancy", 64'(occupancy), 64'd0);
      applyStimulus(1'b1, 64'hA, 1'b1);
      tick();
      applyStimulus(1'b1, 64'hB, 1'b1);
      tick();
      drain();
      checkOutput("postreset_count", 64'(delivered.size()), 64'd2);
      if (delivered.size() == 2) begin
         checkOutput("postreset_word0", delivered[0], 64'hA);
         checkOutput("postreset_word1", delivered[1], 64'hB);
      end

      // Random valid/ready at 50%, the queue model does the checking.
      delivered.delete();
      acc = 0;
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
         if (in_valid && in_ready) acc++;
         tick();
      end
      drain();
      checkOutput("random_count", 64'(delivered.size()), 64'(acc));

`ifdef ROUND_PIPE_FLUSH_EN
      // Flush with an input offered in the same cycle.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 64'h400 + 64'(i), 1'b0);
         tick();
      end
      checkOutput("preflush_occupancy", 64'(occupancy), 64'd3);
      delivered.delete();
      flush = 1'b1;
      applyStimulus(1'b1, 64'hF00D, 1'b0);
      tick();
      flush = 1'b0;
      checkOutput("flush_occupancy", 64'(occupancy), 64'd0);
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      applyStimulus(1'b0, '0, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("flush_nothing_delivered", 64'(delivered.size()), 64'd0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
